// File: rtl/router_port_arbiter_if.sv
// Port bundle for router_port_arbiter: two source flit channels, the downstream
// flit channel with packet framing, and status. The arbiter takes the slave side.
interface router_port_arbiter_if #(
   parameter int W     = 30,
   parameter int CNT_W = 8
);
   logic             a_valid;
   logic [W-1:0]     a_data;
   logic             a_ready;
   logic             b_valid;
   logic [W-1:0]     b_data;
   logic             b_ready;
   logic             o_valid;
   logic [W-1:0]     o_data;
   logic             o_src;
   logic             o_first;
   logic             o_last;
   logic             o_ready;
   logic             busy;
   logic [CNT_W-1:0] pkt_cnt_a;
   logic [CNT_W-1:0] pkt_cnt_b;

   modport slave (
      input  a_valid, a_data, b_valid, b_data, o_ready,
      output a_ready, b_ready, o_valid, o_data, o_src, o_first, o_last,
             busy, pkt_cnt_a, pkt_cnt_b
   );

   modport master (
      output a_valid, a_data, b_valid, b_data, o_ready,
      input  a_ready, b_ready, o_valid, o_data, o_src, o_first, o_last,
             busy, pkt_cnt_a, pkt_cnt_b
   );
endinterface

// File: rtl/router_port_arbiter.sv
// Round-robin two-source packet arbiter: the grant is locked for a whole packet
// (header + L payload flits) and flits pass through combinationally.
module router_port_arbiter #(
   parameter int W     = 30,
   parameter int LEN_W = 4,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   router_port_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

   state_t                 state, state_nx;
   logic                   sel, sel_nx;
   logic                   prio, prio_nx;
   logic [LEN_W-1:0]       rem, rem_nx;
   logic [LEN_W-1:0]       len;
   logic [1:0]             req;
   logic [1:0][W-1:0]      din;
   logic [1:0][CNT_W-1:0]  cnt;
   logic [W-1:0]           sel_data;
   logic                   held, xfer, done;

   // Sources indexed by their o_src code: 0 = A, 1 = B.
   assign req      = {bus.b_valid, bus.a_valid};
   assign din      = {bus.b_data, bus.a_data};
   assign sel_data = din[sel];
   assign len      = sel_data[LEN_W-1:0];
   assign held     = (state != IDLE);

   assign bus.o_valid   = held & req[sel];
   assign bus.o_data    = held ? sel_data : '0;
   assign bus.a_ready   = held & ~sel & bus.o_ready;
   assign bus.b_ready   = held &  sel & bus.o_ready;
   assign xfer          = bus.o_valid & bus.o_ready;
   assign bus.o_first   = (state == HDR);
   assign bus.o_last    = ((state == HDR) && (len == '0)) ||
                          ((state == PAY) && (rem == LEN_W'(1)));
   assign bus.o_src     = sel;
   assign bus.busy      = held;
   assign bus.pkt_cnt_a = cnt[0];
   assign bus.pkt_cnt_b = cnt[1];

   always_comb begin
      state_nx = state;
      sel_nx   = sel;
      prio_nx  = prio;
      rem_nx   = rem;
      done     = 1'b0;
      case (state)
         IDLE: if (|req) begin
            sel_nx   = (&req) ? prio : req[1];
            state_nx = HDR;
         end
         HDR: if (xfer) begin
            if (len == '0) done = 1'b1;
            else begin
               rem_nx   = len;
               state_nx = PAY;
            end
         end
         PAY: if (xfer) begin
            if (rem == LEN_W'(1)) done = 1'b1;
            else rem_nx = rem - LEN_W'(1);
         end
         default: state_nx = IDLE;
      endcase
      // Pointer flips on every completion, even with no competing request.
      if (done) begin
         state_nx = IDLE;
         prio_nx  = ~sel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sel   <= 1'b0;
         prio  <= 1'b0;
         rem   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         sel   <= sel_nx;
         prio  <= prio_nx;
         rem   <= rem_nx;
         if (done) cnt[sel] <= cnt[sel] + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_router_port_arbiter.sv
// Directed bench for router_port_arbiter: reset, single packet, contention,
// backpressure, source gap, mid-packet reset and counter wrap.
module tb_router_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   router_port_arbiter_if #(.W(30), .CNT_W(8)) bus ();

   router_port_arbiter #(.W(30), .LEN_W(4), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      total++;
      if ({bus.busy, bus.o_valid, bus.a_ready, bus.b_ready, bus.o_first, bus.o_last, bus.o_src} !== 7'b0) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=0000000",
                  {bus.busy, bus.o_valid, bus.a_ready, bus.b_ready, bus.o_first, bus.o_last, bus.o_src});
      end
      total++;
      if (bus.pkt_cnt_a !== 8'd0 || bus.pkt_cnt_b !== 8'd0) begin
         bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", bus.pkt_cnt_a, bus.pkt_cnt_b);
      end
      rst = 1'b0;
   endtask

   task automatic test_single_a;
      logic [29:0] hdr = 30'h0ABC_0003;
      logic [29:0] pl;
      bus.a_valid = 1'b1; bus.a_data = hdr; bus.o_ready = 1'b1;
      #1;
      total++;
      if ({bus.busy, bus.o_valid, bus.a_ready} !== 3'b000) begin
         bad++; $display("FAIL single_arb_cycle got=%b want=000", {bus.busy, bus.o_valid, bus.a_ready});
      end
      tick();
      total++;
      if ({bus.o_valid, bus.o_first, bus.o_last, bus.o_src, bus.a_ready} !== 5'b11001 || bus.o_data !== hdr) begin
         bad++; $display("FAIL single_hdr got=%b data=%h want=11001 data=%h",
                         {bus.o_valid, bus.o_first, bus.o_last, bus.o_src, bus.a_ready}, bus.o_data, hdr);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         pl = 30'h1000_0000 + 30'(i);
         bus.a_data = pl;
         #1;
         total++;
         if ({bus.o_valid, bus.o_first, bus.o_last} !== {2'b10, (i == 3)} || bus.o_data !== pl) begin
            bad++; $display("FAIL single_pay%0d got=%b data=%h want=%b data=%h", i,
                            {bus.o_valid, bus.o_first, bus.o_last}, bus.o_data, {2'b10, (i == 3)}, pl);
         end
      end
      tick();
      bus.a_valid = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.pkt_cnt_a !== 8'd1 || dut.prio !== 1'b1) begin
         bad++; $display("FAIL single_done busy=%b cnt_a=%0d prio=%b want 0/1/1", bus.busy, bus.pkt_cnt_a, dut.prio);
      end
   endtask

   task automatic test_contention;
      logic [29:0] ha = 30'h0AAA_A000;
      logic [29:0] hb = 30'h0BBB_B000;
      logic        exp;
      do_reset();
      bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.a_data = ha; bus.b_data = hb; bus.o_ready = 1'b1;
      for (int p = 0; p < 4; p++) begin
         exp = p[0];
         tick();
         total++;
         if (bus.busy !== 1'b1 || bus.o_src !== exp || bus.o_data !== (exp ? hb : ha) || bus.o_last !== 1'b1 ||
             bus.a_ready !== ~exp || bus.b_ready !== exp) begin
            bad++; $display("FAIL contention_pkt%0d busy=%b src=%b data=%h last=%b want src=%b data=%h", p,
                            bus.busy, bus.o_src, bus.o_data, bus.o_last, exp, (exp ? hb : ha));
         end
         tick();
         if (p == 3) begin bus.a_valid = 1'b0; bus.b_valid = 1'b0; end
         total++;
         if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL contention_gap%0d busy=%b want=0", p, bus.busy);
         end
      end
      #1;
      total++;
      if (bus.pkt_cnt_a !== 8'd2 || bus.pkt_cnt_b !== 8'd2) begin
         bad++; $display("FAIL contention_counts got=%0d/%0d want=2/2", bus.pkt_cnt_a, bus.pkt_cnt_b);
      end
   endtask

   task automatic test_backpressure;
      logic        rdy_t  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [3:0]  rem_t  [5] = '{4'd0, 4'd2, 4'd2, 4'd1, 4'd1};
      logic        last_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [29:0] dat    [5];
      int          nx = 0;
      dat[0] = 30'h0B00_0002; dat[1] = 30'h0B00_1111; dat[2] = 30'h0B00_1111;
      dat[3] = 30'h0B00_2222; dat[4] = 30'h0B00_2222;
      bus.b_valid = 1'b1; bus.b_data = dat[0]; bus.o_ready = 1'b1;
      tick();
      bus.a_valid = 1'b1; bus.a_data = 30'h0A00_0000;
      for (int c = 0; c < 5; c++) begin
         bus.o_ready = rdy_t[c]; bus.b_data = dat[c];
         #1;
         total++;
         if (bus.b_ready !== rdy_t[c] || bus.a_ready !== 1'b0 || bus.o_src !== 1'b1 ||
             bus.o_last !== last_t[c] || dut.rem !== rem_t[c] || bus.o_data !== dat[c]) begin
            bad++; $display("FAIL backpressure_c%0d b_rdy=%b a_rdy=%b src=%b last=%b rem=%0d want b_rdy=%b last=%b rem=%0d",
                            c, bus.b_ready, bus.a_ready, bus.o_src, bus.o_last, dut.rem, rdy_t[c], last_t[c], rem_t[c]);
         end
         if (bus.o_valid && bus.o_ready) nx++;
         tick();
      end
      bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.o_ready = 1'b1;
      #1;
      total++;
      if (nx != 3 || bus.busy !== 1'b0 || bus.pkt_cnt_b !== 8'd3) begin
         bad++; $display("FAIL backpressure_done xfers=%0d busy=%b cnt_b=%0d want 3/0/3", nx, bus.busy, bus.pkt_cnt_b);
      end
   endtask

   task automatic test_source_gap;
      logic        v_t [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [29:0] d_t [5];
      logic [29:0] ha = 30'h0D00_0000;
      d_t[0] = 30'h0C00_0002; d_t[1] = 30'h0C00_0BAD; d_t[2] = 30'h0C00_0BAD;
      d_t[3] = 30'h0C00_1111; d_t[4] = 30'h0C00_2222;
      bus.b_valid = 1'b1; bus.b_data = d_t[0]; bus.a_valid = 1'b0; bus.o_ready = 1'b1;
      tick();
      bus.a_valid = 1'b1; bus.a_data = ha;
      for (int c = 0; c < 5; c++) begin
         bus.b_valid = v_t[c]; bus.b_data = d_t[c];
         #1;
         total++;
         if (bus.busy !== 1'b1 || bus.o_src !== 1'b1 || bus.a_ready !== 1'b0 || bus.o_valid !== v_t[c] ||
             bus.o_last !== (c == 4)) begin
            bad++; $display("FAIL gap_c%0d busy=%b src=%b a_rdy=%b o_valid=%b last=%b want 1/1/0/%b/%b",
                            c, bus.busy, bus.o_src, bus.a_ready, bus.o_valid, bus.o_last, v_t[c], (c == 4));
         end
         tick();
      end
      bus.b_valid = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.pkt_cnt_b !== 8'd4) begin
         bad++; $display("FAIL gap_b_done busy=%b cnt_b=%0d want 0/4", bus.busy, bus.pkt_cnt_b);
      end
      tick();
      total++;
      if ({bus.busy, bus.o_src, bus.o_first, bus.o_last, bus.a_ready} !== 5'b10111 || bus.o_data !== ha) begin
         bad++; $display("FAIL gap_a_served got=%b data=%h want=10111 data=%h",
                         {bus.busy, bus.o_src, bus.o_first, bus.o_last, bus.a_ready}, bus.o_data, ha);
      end
      tick();
      bus.a_valid = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.pkt_cnt_a !== 8'd3) begin
         bad++; $display("FAIL gap_a_done busy=%b cnt_a=%0d want 0/3", bus.busy, bus.pkt_cnt_a);
      end
   endtask

   task automatic test_reset_mid;
      bus.a_valid = 1'b1; bus.a_data = 30'h0E00_0007; bus.o_ready = 1'b1;
      tick();
      tick();
      bus.a_data = 30'h0E00_1234;
      tick();
      tick();
      total++;
      if (dut.rem !== 4'd5 || bus.busy !== 1'b1 || bus.o_first !== 1'b0) begin
         bad++; $display("FAIL midrst_setup rem=%0d busy=%b first=%b want 5/1/0", dut.rem, bus.busy, bus.o_first);
      end
      rst = 1'b1;
      tick();
      total++;
      if ({bus.busy, bus.o_valid, bus.a_ready, bus.b_ready, bus.o_first, bus.o_last, bus.o_src} !== 7'b0 ||
          bus.pkt_cnt_a !== 8'd0 || bus.pkt_cnt_b !== 8'd0) begin
         bad++; $display("FAIL midrst_cleared outs=%b cnt=%0d/%0d want 0000000 0/0",
                         {bus.busy, bus.o_valid, bus.a_ready, bus.b_ready, bus.o_first, bus.o_last, bus.o_src},
                         bus.pkt_cnt_a, bus.pkt_cnt_b);
      end
      rst = 1'b0; bus.a_data = 30'h0E00_0000;
      tick();
      total++;
      if ({bus.busy, bus.o_src, bus.o_first, bus.o_last, bus.a_ready} !== 5'b10111) begin
         bad++; $display("FAIL midrst_fresh got=%b want=10111", {bus.busy, bus.o_src, bus.o_first, bus.o_last, bus.a_ready});
      end
      tick();
      bus.a_valid = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.pkt_cnt_a !== 8'd1) begin
         bad++; $display("FAIL midrst_done busy=%b cnt_a=%0d want 0/1", bus.busy, bus.pkt_cnt_a);
      end
   endtask

   task automatic test_wrap;
      do_reset();
      bus.a_valid = 1'b1; bus.a_data = 30'h0F00_0000; bus.b_valid = 1'b0; bus.o_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         tick();
         tick();
         if (i == 254) begin
            total++;
            if (bus.pkt_cnt_a !== 8'd255) begin
               bad++; $display("FAIL wrap_255 cnt_a=%0d want=255", bus.pkt_cnt_a);
            end
         end
      end
      bus.a_valid = 1'b0;
      #1;
      total++;
      if (bus.pkt_cnt_a !== 8'd0 || bus.pkt_cnt_b !== 8'd0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL wrap_zero cnt=%0d/%0d busy=%b want 0/0/0", bus.pkt_cnt_a, bus.pkt_cnt_b, bus.busy);
      end
   endtask

   initial begin
      bus.a_valid = 1'b0; bus.a_data = '0;
      bus.b_valid = 1'b0; bus.b_data = '0;
      bus.o_ready = 1'b0;
      test_reset();
      test_single_a();
      test_contention();
      test_backpressure();
      test_source_gap();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/router_port_arbiter.md
# router_port_arbiter

Two-input packet arbiter that shares one downstream router datapath (30-bit header/flit bus) between port A and port B. It performs round-robin arbitration and locks the grant for a whole variable-length packet. It forwards flits with valid/ready handshakes and keeps per-source packet counters. It sits in front of the combinational routing-decision logic, so only one source's flits reach it at a time.

## Interface
- W, default 30: flit/header width.
- LEN_W, default 4: width of the length field in header bits [LEN_W-1:0], which gives the number of payload flits following the header (0..2^LEN_W-1).
- CNT_W, default 8: width of each per-source packet counter.

Ports, listed as name, direction, width, meaning:
- clk, in, 1: sole clock. All state updates on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- a_valid, in, 1: port A flit valid.
- a_data, in, W: port A flit.
- a_ready, out, 1: port A flit accepted this cycle when a_valid is also high.
- b_valid, in, 1: port B flit valid.
- b_data, in, W: port B flit.
- b_ready, out, 1: port B flit accepted this cycle when b_valid is also high.
- o_valid, out, 1: flit valid toward the datapath.
- o_data, out, W: forwarded flit.
- o_src, out, 1: source of the current packet (0 = A, 1 = B).
- o_first, out, 1: current o_data is the header flit.
- o_last, out, 1: current o_data is the final flit of the packet.
- o_ready, in, 1: downstream accepts.
- busy, out, 1: a grant is held.
- pkt_cnt_a, out, CNT_W: completed packets from A, wraps modulo 2^CNT_W.
- pkt_cnt_b, out, CNT_W: completed packets from B, wraps modulo 2^CNT_W.

## Operation
- States:
  - IDLE: no grant.
  - HDR: grant held, header flit not yet accepted.
  - PAY: grant held, payload flits pending.
- Round-robin pointer `prio` (0 = A preferred). Reset value 0.
- IDLE behaviour:
  - If exactly one of a_valid/b_valid is high, that source wins.
  - If both are high, the source given by `prio` wins.
  - If neither is high, stay in IDLE.
  - On a win: register `sel` = winner and go to HDR.
- HDR/PAY behaviour, pure pass-through of the selected port:
  - o_valid = sel_valid, o_data = sel_data, sel_ready = o_ready.
  - The non-selected port's ready is 0.
  - A transfer is the cycle where o_valid and o_ready are both high.
- HDR transfer:
  - If the length field L = 0, the packet completes.
  - Otherwise load `rem` = L and go to PAY.
- PAY transfer:
  - If rem = 1, the packet completes.
  - Otherwise rem decrements by 1.
- Packet completion:
  - Go to IDLE.
  - Set prio = ~sel. This applies even if the other port was idle.
  - Increment the selected source's pkt_cnt.
- o_first = (state == HDR).
- o_last = (state == HDR and L == 0) or (state == PAY and rem == 1).
- o_src = sel. busy = (state != IDLE).
- Stalls:
  - If o_ready is low, or the selected valid drops mid-packet, the grant is held and rem is unchanged.
  - The packet never interleaves with the other source.
- Both counters wrap from 2^CNT_W-1 to 0 without a flag.

## Timing
- Reset values:
  - state IDLE, sel 0, prio 0, rem 0, pkt_cnt_a/b 0.
  - All outputs 0: a_ready, b_ready, o_valid, o_first, o_last, o_src, busy.
- Reset asserted mid-packet:
  - The next edge forces IDLE and clears the counters.
  - The partially sent packet is abandoned, with no o_last.
- Arbitration latency: one cycle. A request seen in IDLE at edge t produces the grant at t+1, and o_valid/ready become visible from t+1.
- In IDLE, a_ready = b_ready = o_valid = 0. No flit is accepted in the arbitration cycle.
- Data path is combinational: o_* and *_ready have zero added latency while the grant is held.
- Completion and re-arbitration: the cycle after the last transfer is IDLE. The minimum gap between packets is therefore 1 cycle.
- Sustained throughput: a packet of L+1 flits occupies L+2 cycles, including arbitration.

## Test plan
- Single A packet:
  - Stimulus: reset, then A sends header with L=3 and 3 payload flits, o_ready=1.
  - Required response: grant 1 cycle after a_valid; 4 consecutive transfers; o_first on flit 0; o_last on flit 3; pkt_cnt_a=1; prio=1; busy low on the next cycle.
- Contention:
  - Stimulus: A and B both valid in IDLE with prio=0; each sends L=0.
  - Required response: A granted first, then B. Order A, B, A, B over 4 packets when both stay valid.
- Backpressure:
  - Stimulus: o_ready toggles 1,0,1,0 during an L=2 packet from B.
  - Required response: rem holds while o_ready=0; exactly 3 transfers; b_ready mirrors o_ready; a_ready stays 0 throughout.
- Source gap:
  - Stimulus: b_valid drops for 2 cycles mid-payload while a_valid=1.
  - Required response: grant stays on B; A is not served until B's o_last transfer.
- Reset mid-packet:
  - Stimulus: assert rst during PAY with rem=5.
  - Required response: next cycle is IDLE, all outputs 0, counters 0; a fresh request is served normally afterwards.
- Counter wrap:
  - Stimulus: 256 L=0 packets from A.
  - Required response: pkt_cnt_a returns to 0; pkt_cnt_b stays unchanged.
